rr_sel_arbiter: RTL and testbench

RR_SEL_ARBITER -- requirements
Module: rr_sel_arbiter

---
 rtl/rr_sel_arbiter.sv | 83 ++++++++
 tb/tb_rr_sel_arbiter.sv | 96 +++++++++
 2 files changed

// File: rtl/rr_sel_arbiter.sv
// rr_sel_arbiter: 4-way round-robin arbiter with registered one-hot grant, binary select and hold timeout
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   req       per-requester request, bit i = requester i
//   done      owner releases the resource (only looked at while busy)
//   gnt       one-hot grant, zero when no owner
//   sel       binary index of the owner, drives the shared datapath mux
//   gnt_valid high while an owner holds the grant
//   timeout   one-cycle pulse after a grant is force-released at MAX_HOLD
module rr_sel_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       gnt_valid,
  output logic       timeout
);
  localparam int CW = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_HOLD);
  localparam logic S_IDLE = 1'b0;
  localparam logic S_BUSY = 1'b1;
  logic          r_state;
  logic [3:0]    r_gnt;
  logic [1:0]    r_sel;
  logic          r_gnt_valid;
  logic          r_timeout;
  logic [CW-1:0] r_hold_cnt;
  logic [1:0]    r_last;
  logic          w_found;
  logic [1:0]    w_pick;
  // Priority search starting just after the last owner; an X request bit
  // simply fails its test, so at most one index is ever chosen.
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_last;
    for (int i = 1; i <= 4; i++) begin
      if (!w_found && req[2'(r_last + 2'(i))]) begin
        w_found = 1'b1;
        w_pick  = 2'(r_last + 2'(i));
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_gnt       <= 4'b0;
      r_sel       <= 2'd0;
      r_gnt_valid <= 1'b0;
      r_timeout   <= 1'b0;
      r_hold_cnt  <= '0;
      r_last      <= 2'd3;
    end else begin
      r_timeout <= 1'b0;
      if (r_state == S_IDLE) begin
        if (w_found) begin
          r_state     <= S_BUSY;
          r_sel       <= w_pick;
          r_gnt       <= 4'b1 << w_pick;
          r_gnt_valid <= 1'b1;
          r_hold_cnt  <= CW'(1);
        end
      end else if (done || r_hold_cnt == MAX_CNT) begin
        // done wins over the hold limit, so timeout only flags a forced release
        r_state     <= S_IDLE;
        r_gnt       <= 4'b0;
        r_gnt_valid <= 1'b0;
        r_last      <= r_sel;
        r_timeout   <= !done;
      end else begin
        r_hold_cnt <= r_hold_cnt + CW'(1);
      end
    end
  end
  assign gnt       = r_gnt;
  assign sel       = r_sel;
  assign gnt_valid = r_gnt_valid;
  assign timeout   = r_timeout;
endmodule

// File: tb/tb_rr_sel_arbiter.sv
// tb_rr_sel_arbiter: directed scoreboard bench for rr_sel_arbiter
module tb_rr_sel_arbiter;
  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       gnt_valid;
  logic       timeout;
  int checks = 0;
  int passed = 0;
  typedef struct {
    string      tag;
    logic [7:0] exp;
  } exp_t;
  exp_t sb[$];
  rr_sel_arbiter #(.MAX_HOLD(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .gnt(gnt), .sel(sel), .gnt_valid(gnt_valid), .timeout(timeout)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string t, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got {gnt,sel,valid,timeout}=%b want %b", t, got, exp);
  endtask
  task automatic step(input logic [3:0] rq, input logic d, input logic [3:0] eg,
                      input logic [1:0] es, input logic ev, input logic et, input string t);
    exp_t e;
    req  = rq;
    done = d;
    sb.push_back('{tag: t, exp: {eg, es, ev, et}});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk(e.tag, {gnt, sel, gnt_valid, timeout}, e.exp);
  endtask
  initial begin
    logic [1:0] g;
    rst_n = 1'b0;
    req   = 4'b0;
    done  = 1'b0;
    #12;
    chk("reset_state", {gnt, sel, gnt_valid, timeout}, 8'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      g = 2'(k);
      step(4'b1111, 1'b0, 4'b1 << g, g, 1'b1, 1'b0, "rr_grant");
      step(4'b1111, 1'b0, 4'b1 << g, g, 1'b1, 1'b0, "rr_hold");
      step(4'b1111, 1'b1, 4'b0,      g, 1'b0, 1'b0, "rr_release");
    end
    for (int k = 0; k < 4; k++) begin
      g = (k % 2 == 0) ? 2'd1 : 2'd3;
      step(4'b1010, 1'b0, 4'b1 << g, g, 1'b1, 1'b0, "alt_grant");
      step(4'b1010, 1'b1, 4'b0,      g, 1'b0, 1'b0, "alt_release");
    end
    for (int k = 1; k <= 8; k++)
      step(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, "maxhold_hold");
    step(4'b0100, 1'b0, 4'b0000, 2'd2, 1'b0, 1'b1, "timeout_pulse");
    step(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, "timeout_regrant");
    for (int k = 2; k <= 8; k++)
      step(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, "maxhold_hold2");
    step(4'b0100, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0, "done_at_max_no_timeout");
    step(4'b0000, 1'b0, 4'b0000, 2'd2, 1'b0, 1'b0, "idle_sel_holds");
    step(4'b0000, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0, "idle_done_ignored");
    step(4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0, "owner1_grant");
    for (int k = 0; k < 3; k++)
      step(4'b1000, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0, "owner1_stable");
    step(4'b1000, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0, "owner1_release");
    step(4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0, "grant3_after_idle");
    step(4'b1000, 1'b1, 4'b0000, 2'd3, 1'b0, 1'b0, "release3");
    step(4'b0001, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0, "idle_done_then_grant0");
    #2;
    rst_n = 1'b0;
    req   = 4'b0;
    done  = 1'b0;
    #1;
    chk("async_reset_owner0", {gnt, sel, gnt_valid, timeout}, 8'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0, "post_reset_grant3");
    step(4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0, "post_reset_hold3");
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_owner3", {gnt, sel, gnt_valid, timeout}, 8'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b0011, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, "post_reset2_grant0");
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
